// File: rtl/gf2m_reduce_seq_if.sv
// Strobe/busy/done handshake between the multiplier core, the reducer and the
// point add/double state machine.
interface gf2m_reduce_seq_if #(
    parameter int M = 127
);
    logic           Data_Valid;
    logic [255:0]   C_In;
    logic           Out_Busy;
    logic           Done;
    logic [M-1:0]   C_Out;

    modport master (
        output Data_Valid, C_In,
        input  Out_Busy, Done, C_Out
    );

    modport slave (
        input  Data_Valid, C_In,
        output Out_Busy, Done, C_Out
    );
endinterface

// File: rtl/gf2m_reduce_seq.sv
// Sequential GF(2^M) reducer: folds a 256-bit carry-less product modulo x^M + POLY,
// DIGIT bits per cycle, MSB first. Optional early exit: GF2M_REDUCE_ZERO_SKIP_EN.
module gf2m_reduce_seq #(
    parameter int           M     = 127,
    parameter logic [M-1:0] POLY  = M'(3),
    parameter int           DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    gf2m_reduce_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_e;

    state_e         state_q;
    logic [255:0]   work_q;
    logic [255:0]   work_d;
    logic [7:0]     idx_q;
    logic           busy_q;
    logic           done_q;
    logic [M-1:0]   c_out_q;
    logic           last_group;
    logic [255:0]   poly_ext;

    assign poly_ext   = {{(256-M){1'b0}}, POLY};
    assign last_group = (int'(idx_q) - DIGIT + 1) <= M;

`ifdef GF2M_REDUCE_ZERO_SKIP_EN
    // Bits above idx are already cleared, so the whole upper field suffices.
    logic nothing_left;
    assign nothing_left = (work_q[255:M] == '0);
`endif

    // One group of DIGIT folds, chained MSB first within the cycle.
    always_comb begin
        int i;
        i      = 0;
        work_d = work_q;
        for (int j = 0; j < DIGIT; j++) begin
            i = int'(idx_q) - j;
            if (i >= M) begin
                if (work_d[i[7:0]]) begin
                    work_d[i[7:0]] = 1'b0;
                    work_d         = work_d ^ (poly_ext << (i - M));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_out_q <= '0;
            work_q  <= '0;
            idx_q   <= 8'd255;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Data_Valid) begin
                        work_q  <= bus.C_In;
                        idx_q   <= 8'd255;
                        busy_q  <= 1'b1;
                        state_q <= REDUCE;
                    end
                end
                REDUCE: begin
`ifdef GF2M_REDUCE_ZERO_SKIP_EN
                    if (nothing_left) begin
                        c_out_q <= work_q[M-1:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
`else
                    begin
`endif
                        work_q <= work_d;
                        idx_q  <= 8'(int'(idx_q) - DIGIT);
                        if (last_group) begin
                            c_out_q <= work_d[M-1:0];
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Out_Busy = busy_q;
    assign bus.Done     = done_q;
    assign bus.C_Out    = c_out_q;
endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Randomised bench for gf2m_reduce_seq against a table of x^k mod f(x).
module tb_gf2m_reduce_seq;
    localparam int           M     = 127;
    localparam int           DIGIT = 8;
    localparam logic [M-1:0] POLY  = 127'h3;
    localparam int           N     = (256 - M + DIGIT - 1) / DIGIT;
    localparam int           WIN   = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [M-1:0] pw [256];

    gf2m_reduce_seq_if #(.M(M)) bif ();

    gf2m_reduce_seq #(.M(M), .POLY(POLY), .DIGIT(DIGIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // x^k mod f(x) for every k, built by repeated multiplication by x.
    task automatic build_table();
        logic [M-1:0] r;
        logic         carry;
        r = M'(1);
        for (int k = 0; k < 256; k++) begin
            pw[k] = r;
            carry = r[M-1];
            r     = r << 1;
            if (carry) r = r ^ POLY;
        end
    endtask

    function automatic logic [M-1:0] model(input logic [255:0] c);
        logic [M-1:0] acc;
        acc = '0;
        for (int k = 0; k < 256; k++)
            if (c[k]) acc = acc ^ pw[k];
        return acc;
    endfunction

    // inj_k >= 1: pulse a second Data_Valid after edge inj_k; inj_k == -2: pulse it while Done is high.
    task automatic run_txn(input logic [255:0] c, input int inj_k, input logic [255:0] inj_val,
                           output int lat, output logic [M-1:0] res, output int busycnt,
                           output int ndone, output int busy_after);
        int first;
        first = -1; ndone = 0; busycnt = 0; busy_after = 0; res = '0;
        @(negedge clk);
        bif.Data_Valid = 1'b1;
        bif.C_In       = c;
        @(posedge clk);
        #1;
        bif.Data_Valid = 1'b0;
        if (bif.Out_Busy) busycnt++;
        for (int k = 1; k <= WIN; k++) begin
            @(posedge clk);
            #1;
            bif.Data_Valid = 1'b0;
            if (bif.Done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    res   = bif.C_Out;
                    if (inj_k == -2) begin
                        bif.Data_Valid = 1'b1;
                        bif.C_In       = inj_val;
                    end
                end
            end else if (first < 0 && bif.Out_Busy) begin
                busycnt++;
            end else if (first >= 0 && bif.Out_Busy) begin
                busy_after++;
            end
            if (k == inj_k) begin
                bif.Data_Valid = 1'b1;
                bif.C_In       = inj_val;
            end
        end
        bif.Data_Valid = 1'b0;
        lat = (first < 0) ? -1 : first + 1;
    endtask

    task automatic expect_lat(input string tag, input int lat, input logic [255:0] c);
`ifdef GF2M_REDUCE_ZERO_SKIP_EN
        if (c[255:M] == '0) check(tag, lat, 2);
        else                check(tag, (lat >= 2 && lat <= N + 1), 1);
`else
        check(tag, lat, N + 1);
`endif
    endtask

    initial begin
        int           lat, busycnt, ndone, busy_after;
        logic [M-1:0] res;
        logic [255:0] c;

        build_table();
        bif.Data_Valid = 1'b0;
        bif.C_In       = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bif.Out_Busy, 0);
        check("rst_done", bif.Done, 0);
        check("rst_cout", bif.C_Out, 0);
        rst = 1'b0;

        run_txn(256'h0, 0, '0, lat, res, busycnt, ndone, busy_after);
        check("zero_res", res, 0);
        expect_lat("zero_lat", lat, 256'h0);
        check("zero_busy", busycnt, lat - 1);

        c = 256'h1 << 127;
        run_txn(c, 0, '0, lat, res, busycnt, ndone, busy_after);
        check("x127_res", res, 127'h3);
        expect_lat("x127_lat", lat, c);

        c = 256'h1 << 254;
        run_txn(c, 0, '0, lat, res, busycnt, ndone, busy_after);
        check("x254_res", res, 127'h5);
        expect_lat("x254_lat", lat, c);
        check("x254_busy", busycnt, lat - 1);

        c = 256'h1234;
        run_txn(c, 0, '0, lat, res, busycnt, ndone, busy_after);
        check("low_res", res, 127'h1234);
        expect_lat("low_lat", lat, c);

        c = 256'h1 << 254;
        run_txn(c, 5, 256'h1 << 127, lat, res, busycnt, ndone, busy_after);
        check("ign_busy_res", res, 127'h5);
        check("ign_busy_ndone", ndone, 1);
        check("ign_busy_after", busy_after, 0);

        c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_txn(c, -2, 256'h1 << 127, lat, res, busycnt, ndone, busy_after);
        check("ign_done_res", res, model(c));
        check("ign_done_ndone", ndone, 1);
        check("ign_done_after", busy_after, 0);

        for (int t = 0; t < 24; t++) begin
            c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (t % 6 == 5) c[255:M] = '0;
            if (t % 6 == 4) c = c >> $urandom_range(1, 200);
            run_txn(c, 0, '0, lat, res, busycnt, ndone, busy_after);
            check("rand_res", res, model(c));
            expect_lat("rand_lat", lat, c);
            check("rand_busy", busycnt, lat - 1);
        end

        // Reset in the middle of a reduction discards it.
        @(negedge clk);
        bif.Data_Valid = 1'b1;
        bif.C_In       = 256'h1 << 254;
        @(negedge clk);
        bif.Data_Valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", bif.Out_Busy, 0);
        check("mid_rst_done", bif.Done, 0);
        check("mid_rst_cout", bif.C_Out, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("mid_rst_quiet", {bif.Out_Busy, bif.Done}, 0);
        end

        c = 256'h1 << 127;
        run_txn(c, 0, '0, lat, res, busycnt, ndone, busy_after);
        check("post_rst_res", res, 127'h3);
        expect_lat("post_rst_lat", lat, c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
